// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor (PC xor global history) with a direct-mapped BTB and a post-reset PHT init sweep.
// Optional feature macro BP_PERF_CNT_EN adds saturating branch and misprediction counters.
module gshare_branch_predictor #(
   parameter int XLEN      = 32,
   parameter int PHT_IDX_W = 10,
   parameter int GHR_W     = 8,
   parameter int CTR_W     = 2,
   parameter int BTB_IDX_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   output logic             ready,
`ifdef BP_PERF_CNT_EN
   output logic [31:0]      perf_branches,
   output logic [31:0]      perf_mispred,
`endif
   input  logic [XLEN-1:0]  lk_pc,
   output logic             lk_taken,
   output logic [XLEN-1:0]  lk_target,
   output logic [GHR_W-1:0] lk_ghr,
   input  logic             upd_valid,
   input  logic             upd_cond,
   input  logic [XLEN-1:0]  upd_pc,
   input  logic [GHR_W-1:0] upd_ghr,
   input  logic             upd_actual,
   input  logic [XLEN-1:0]  upd_target
);

   localparam int PHT_N = 1 << PHT_IDX_W;
   localparam int BTB_N = 1 << BTB_IDX_W;
   localparam int TAG_W = XLEN - BTB_IDX_W - 2;

   localparam logic [CTR_W-1:0]     CTR_MAX   = {CTR_W{1'b1}};
   localparam logic [CTR_W-1:0]     CTR_WNT   = {1'b0, {(CTR_W-1){1'b1}}};
   localparam logic [PHT_IDX_W-1:0] PHT_LAST  = {PHT_IDX_W{1'b1}};

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Saturating up/down step of a direction counter.
   function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] ctr, input logic up);
      logic [CTR_W-1:0] res;
      res = ctr;
      if (up) begin
         if (ctr != CTR_MAX) res = ctr + CTR_W'(1);
         else                res = ctr;
      end else begin
         if (ctr != {CTR_W{1'b0}}) res = ctr - CTR_W'(1);
         else                      res = ctr;
      end
      return res;
   endfunction

   state_t                 state_q, state_d;
   logic                   ready_q, ready_d;
   logic [PHT_IDX_W-1:0]   sweep_q, sweep_d;
   logic [GHR_W-1:0]       ghr_q, ghr_d, ghr_shift_s;
   logic [BTB_N-1:0]       btb_valid_q, btb_valid_d;

   logic [CTR_W-1:0]       pht_q [PHT_N];
   logic [TAG_W-1:0]       btb_tag_q [BTB_N];
   logic [XLEN-1:0]        btb_target_q [BTB_N];
   logic [BTB_N-1:0]       btb_uncond_q;

   logic                   run_s, upd_en_s, upd_cond_en_s, upd_btb_en_s;
   logic [PHT_IDX_W-1:0]   ghr_ext_s, upd_ghr_ext_s;
   logic [PHT_IDX_W-1:0]   lk_pidx_s, upd_pidx_s;
   logic [BTB_IDX_W-1:0]   lk_bidx_s, upd_bidx_s;
   logic [TAG_W-1:0]       lk_tag_s, upd_tag_s;
   logic [CTR_W-1:0]       upd_ctr_s;
   logic                   lk_hit_s, lk_pred_s;
   logic                   pht_we_s;
   logic [PHT_IDX_W-1:0]   pht_widx_s;
   logic [CTR_W-1:0]       pht_wdata_s;
   logic                   unused_pc_bits_s;

   assign run_s         = (state_q == ST_RUN);
   assign upd_en_s      = run_s && upd_valid;
   assign upd_cond_en_s = upd_en_s && upd_cond;
   assign upd_btb_en_s  = upd_en_s && upd_actual;

   // Instruction-aligned PCs: the two low bits never index anything.
   assign unused_pc_bits_s = ^{lk_pc[1:0], upd_pc[1:0]};

   // Zero-extend live and carried histories to PHT index width.
   always_comb begin
      ghr_ext_s                   = {PHT_IDX_W{1'b0}};
      upd_ghr_ext_s               = {PHT_IDX_W{1'b0}};
      ghr_ext_s[GHR_W-1:0]        = ghr_q;
      upd_ghr_ext_s[GHR_W-1:0]    = upd_ghr;
   end

   assign lk_pidx_s  = lk_pc[PHT_IDX_W+1:2] ^ ghr_ext_s;
   assign lk_bidx_s  = lk_pc[BTB_IDX_W+1:2];
   assign lk_tag_s   = lk_pc[XLEN-1:BTB_IDX_W+2];
   assign upd_pidx_s = upd_pc[PHT_IDX_W+1:2] ^ upd_ghr_ext_s;
   assign upd_bidx_s = upd_pc[BTB_IDX_W+1:2];
   assign upd_tag_s  = upd_pc[XLEN-1:BTB_IDX_W+2];
   assign upd_ctr_s  = pht_q[upd_pidx_s];

   generate
      if (GHR_W == 1) begin : g_ghr_one
         assign ghr_shift_s = upd_actual;
      end else begin : g_ghr_wide
         assign ghr_shift_s = {ghr_q[GHR_W-2:0], upd_actual};
      end
   endgenerate

   // Control state register with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_INIT;
         ready_q     <= 1'b0;
         sweep_q     <= {PHT_IDX_W{1'b0}};
         ghr_q       <= {GHR_W{1'b0}};
         btb_valid_q <= {BTB_N{1'b0}};
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         sweep_q     <= sweep_d;
         ghr_q       <= ghr_d;
         btb_valid_q <= btb_valid_d;
      end
   end

   // Next-state: sweep every PHT entry once, then stay live until reset.
   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      case (state_q)
         ST_INIT: begin
            sweep_d = sweep_q + PHT_IDX_W'(1);
            if (sweep_q == PHT_LAST) state_d = ST_RUN;
            else                     state_d = ST_INIT;
         end
         ST_RUN: begin
            state_d = ST_RUN;
            sweep_d = sweep_q;
         end
         default: begin
            state_d = ST_INIT;
            sweep_d = {PHT_IDX_W{1'b0}};
         end
      endcase
   end

   // Outputs: ready tracks the upcoming state; lookup is combinational with no update bypass.
   always_comb begin
      ready_d   = (state_d == ST_RUN);
      lk_hit_s  = btb_valid_q[lk_bidx_s] && (btb_tag_q[lk_bidx_s] == lk_tag_s);
      lk_pred_s = pht_q[lk_pidx_s][CTR_W-1];
      lk_taken  = 1'b0;
      lk_target = lk_pc + XLEN'(32'd4);
      if (run_s && lk_hit_s && (btb_uncond_q[lk_bidx_s] || lk_pred_s)) begin
         lk_taken  = 1'b1;
         lk_target = btb_target_q[lk_bidx_s];
      end else begin
         lk_taken  = 1'b0;
         lk_target = lk_pc + XLEN'(32'd4);
      end
   end

   assign ready  = ready_q;
   assign lk_ghr = ghr_q;

   // History shifts only on resolved conditionals; taken outcomes (re)allocate the BTB slot.
   always_comb begin
      ghr_d       = ghr_q;
      btb_valid_d = btb_valid_q;
      if (upd_cond_en_s) ghr_d = ghr_shift_s;
      else               ghr_d = ghr_q;
      if (upd_btb_en_s) btb_valid_d[upd_bidx_s] = 1'b1;
      else              btb_valid_d = btb_valid_q;
   end

   // One PHT write port, owned by the sweep in INIT and by resolution in RUN.
   always_comb begin
      pht_we_s    = 1'b0;
      pht_widx_s  = sweep_q;
      pht_wdata_s = CTR_WNT;
      if (!run_s) begin
         pht_we_s = 1'b1;
      end else if (upd_cond_en_s) begin
         pht_we_s    = 1'b1;
         pht_widx_s  = upd_pidx_s;
         pht_wdata_s = ctr_next(upd_ctr_s, upd_actual);
      end else begin
         pht_we_s = 1'b0;
      end
   end

   // PHT storage; contents are established by the sweep, not by reset.
   always_ff @(posedge clk) begin
      if (pht_we_s) pht_q[pht_widx_s] <= pht_wdata_s;
   end

   // BTB payload; validity lives in btb_valid_q.
   always_ff @(posedge clk) begin
      if (upd_btb_en_s) begin
         btb_tag_q[upd_bidx_s]    <= upd_tag_s;
         btb_target_q[upd_bidx_s] <= upd_target;
         btb_uncond_q[upd_bidx_s] <= ~upd_cond;
      end
   end

`ifdef BP_PERF_CNT_EN
   logic [31:0] perf_br_q, perf_br_d, perf_mp_q, perf_mp_d;

   // Saturating event counters; a misprediction compares against the counter MSB at uidx.
   always_comb begin
      perf_br_d = perf_br_q;
      perf_mp_d = perf_mp_q;
      if (upd_cond_en_s) begin
         if (perf_br_q != 32'hFFFF_FFFF) perf_br_d = perf_br_q + 32'd1;
         else                            perf_br_d = perf_br_q;
         if ((upd_actual != upd_ctr_s[CTR_W-1]) && (perf_mp_q != 32'hFFFF_FFFF)) perf_mp_d = perf_mp_q + 32'd1;
         else                                                                     perf_mp_d = perf_mp_q;
      end else begin
         perf_br_d = perf_br_q;
         perf_mp_d = perf_mp_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_br_q <= 32'd0;
         perf_mp_q <= 32'd0;
      end else begin
         perf_br_q <= perf_br_d;
         perf_mp_q <= perf_mp_d;
      end
   end

   assign perf_branches = perf_br_q;
   assign perf_mispred  = perf_mp_q;
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Scoreboard bench for gshare_branch_predictor (default parameters, BP_PERF_CNT_EN undefined).
module tb_gshare_branch_predictor;

   typedef struct packed {
      logic [127:0] name;
      logic         rdy;
      logic         tkn;
      logic [31:0]  tgt;
      logic [7:0]   ghr;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        ready;
   logic [31:0] lk_pc;
   logic        lk_taken;
   logic [31:0] lk_target;
   logic [7:0]  lk_ghr;
   logic        upd_valid;
   logic        upd_cond;
   logic [31:0] upd_pc;
   logic [7:0]  upd_ghr;
   logic        upd_actual;
   logic [31:0] upd_target;

   exp_t exp_q[$];
   exp_t exp_cur;
   logic probe;
   int   n_vec;
   int   n_miss;

   gshare_branch_predictor dut (
      .clk        (clk),
      .rst        (rst),
      .ready      (ready),
      .lk_pc      (lk_pc),
      .lk_taken   (lk_taken),
      .lk_target  (lk_target),
      .lk_ghr     (lk_ghr),
      .upd_valid  (upd_valid),
      .upd_cond   (upd_cond),
      .upd_pc     (upd_pc),
      .upd_ghr    (upd_ghr),
      .upd_actual (upd_actual),
      .upd_target (upd_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: whenever a lookup is presented, pop the expected response and compare.
   always @(negedge clk) begin
      if (probe) begin
         if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL scoreboard_empty: lookup presented with no expectation queued");
         end else begin
            exp_cur = exp_q.pop_front();
            n_vec++;
            if (ready !== exp_cur.rdy || lk_taken !== exp_cur.tkn ||
                lk_target !== exp_cur.tgt || lk_ghr !== exp_cur.ghr) begin
               n_miss++;
               $display("FAIL %0s: got ready=%b taken=%b target=%h ghr=%h, expected ready=%b taken=%b target=%h ghr=%h",
                        exp_cur.name, ready, lk_taken, lk_target, lk_ghr,
                        exp_cur.rdy, exp_cur.tkn, exp_cur.tgt, exp_cur.ghr);
            end
         end
      end
   end

   task automatic lookup(input logic [127:0] name, input logic [31:0] pc, input logic er,
                         input logic et, input logic [31:0] etgt, input logic [7:0] eghr);
      exp_t e;
      e.name = name; e.rdy = er; e.tkn = et; e.tgt = etgt; e.ghr = eghr;
      lk_pc = pc;
      exp_q.push_back(e);
      probe = 1'b1;
      @(negedge clk);
      #1 probe = 1'b0;
   endtask

   task automatic do_upd(input logic c, input logic [31:0] pc, input logic [7:0] g,
                         input logic a, input logic [31:0] t);
      upd_valid = 1'b1; upd_cond = c; upd_pc = pc; upd_ghr = g; upd_actual = a; upd_target = t;
      @(posedge clk);
      #1 upd_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0; n_miss = 0; probe = 1'b0;
      rst = 1'b1; lk_pc = 32'h0;
      upd_valid = 1'b0; upd_cond = 1'b0; upd_pc = 32'h0; upd_ghr = 8'h0; upd_actual = 1'b0; upd_target = 32'h0;

      #12;
      lookup("rst_idle", 32'h100, 1'b0, 1'b0, 32'h104, 8'h00);
      rst = 1'b0;

      // Updates during the sweep must be ignored.
      do_upd(1'b1, 32'h100, 8'h00, 1'b1, 32'h900);
      repeat (1022) @(posedge clk);
      #1;
      lookup("init_ready0", 32'h100, 1'b0, 1'b0, 32'h104, 8'h00);
      lookup("init_ready1", 32'h100, 1'b1, 1'b0, 32'h104, 8'h00);

      // Gshare indexing: PHT[0x80] trained, lookup at GHR=3 reads PHT[0x83].
      do_upd(1'b1, 32'h200, 8'h00, 1'b1, 32'h180);
      do_upd(1'b1, 32'h200, 8'h00, 1'b1, 32'h180);
      lookup("gs_idx_nt", 32'h200, 1'b1, 1'b0, 32'h204, 8'h03);
      do_upd(1'b1, 32'h200, 8'h03, 1'b1, 32'h180);
      for (int i = 0; i < 6; i++) do_upd(1'b1, 32'h2004, 8'h00, 1'b0, 32'h0);
      for (int i = 0; i < 2; i++) do_upd(1'b1, 32'h2004, 8'h00, 1'b1, 32'h3000);
      lookup("gs_taken", 32'h200, 1'b1, 1'b1, 32'h180, 8'h03);

      // Unconditional jump ignores the PHT and evicts 0x200 from BTB slot 0.
      do_upd(1'b0, 32'h300, 8'h03, 1'b1, 32'h400);
      lookup("jal_hit", 32'h300, 1'b1, 1'b1, 32'h400, 8'h03);
      lookup("jal_evict", 32'h200, 1'b1, 1'b0, 32'h204, 8'h03);

      // Saturation on uidx 0x141^0xFE = 0x1BF.
      for (int i = 0; i < 5; i++) do_upd(1'b1, 32'h504, 8'hFE, 1'b1, 32'h600);
      do_upd(1'b1, 32'h504, 8'hFE, 1'b0, 32'h0);
      lookup("sat_hi", 32'h504, 1'b1, 1'b1, 32'h600, 8'hFE);
      for (int i = 0; i < 3; i++) do_upd(1'b1, 32'h504, 8'hFE, 1'b0, 32'h0);
      for (int i = 0; i < 7; i++) do_upd(1'b1, 32'h2008, 8'h00, 1'b1, 32'h3100);
      do_upd(1'b1, 32'h2008, 8'h00, 1'b0, 32'h0);
      lookup("sat_lo", 32'h504, 1'b1, 1'b0, 32'h508, 8'hFE);

      // BTB aliasing and same-cycle lookup/update.
      do_upd(1'b0, 32'h1000, 8'hFE, 1'b1, 32'h1800);
      lookup("alias_a", 32'h1000, 1'b1, 1'b1, 32'h1800, 8'hFE);
      do_upd(1'b0, 32'h1100, 8'hFE, 1'b1, 32'h1900);
      lookup("alias_evict", 32'h1000, 1'b1, 1'b0, 32'h1004, 8'hFE);
      @(posedge clk);
      #1;
      upd_valid = 1'b1; upd_cond = 1'b0; upd_pc = 32'h1100; upd_ghr = 8'hFE; upd_actual = 1'b1; upd_target = 32'h1A00;
      lookup("same_cycle", 32'h1100, 1'b1, 1'b1, 32'h1900, 8'hFE);
      @(posedge clk);
      #1 upd_valid = 1'b0;
      lookup("after_wr", 32'h1100, 1'b1, 1'b1, 32'h1A00, 8'hFE);
      do_upd(1'b1, 32'h1100, 8'hFE, 1'b0, 32'h0);
      lookup("nt_keep", 32'h1100, 1'b1, 1'b1, 32'h1A00, 8'hFC);
      do_upd(1'b1, 32'h1000, 8'hFC, 1'b0, 32'h0);
      lookup("nt_noalloc", 32'h1000, 1'b1, 1'b0, 32'h1004, 8'hF8);

      // Asynchronous reset between edges, then a full re-sweep.
      @(posedge clk);
      #3 rst = 1'b1;
      lookup("rst_async", 32'h1100, 1'b0, 1'b0, 32'h1104, 8'h00);
      rst = 1'b0;
      repeat (1023) @(posedge clk);
      #1;
      lookup("resweep_busy", 32'h1100, 1'b0, 1'b0, 32'h1104, 8'h00);
      lookup("resweep_ready", 32'h1100, 1'b1, 1'b0, 32'h1104, 8'h00);
      do_upd(1'b1, 32'h208, 8'h00, 1'b1, 32'h280);
      lookup("pht_reinit", 32'h208, 1'b1, 1'b0, 32'h20C, 8'h01);

      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
